// File: rtl/sat_adder_arbiter.sv
// Two-requester round-robin front end sharing one saturating add/sub datapath.
// Operands are captured on grant, the result is captured one cycle later, and a response pulses the cycle after that.
module sat_adder_arbiter #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_ovfl,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_ovfl,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic             sub_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp_sum_q [2];
  logic [1:0]       rsp_ovfl_q;

  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw_sum;
  logic             ovfl_d;
  logic [WIDTH-1:0] result_d;

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
  assign req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;

  // Subtraction folds into the same adder as A + ~B + 1.
  always_comb begin
    b_eff   = sub_q ? ~b_q : b_q;
    raw_sum = a_q + b_eff + {{(WIDTH-1){1'b0}}, sub_q};
    if (sub_q) begin
      ovfl_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw_sum[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovfl_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw_sum[WIDTH-1] != a_q[WIDTH-1]);
    end
    if (SAT && ovfl_d) begin
      result_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      result_d = raw_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      sub_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= '0;
      rsp_sum_q[0] <= '0;
      rsp_sum_q[1] <= '0;
      rsp_ovfl_q   <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q          <= grant_id ? req1_a   : req0_a;
            b_q          <= grant_id ? req1_b   : req0_b;
            sub_q        <= grant_id ? req1_sub : req0_sub;
            owner_q      <= grant_id;
            last_grant_q <= grant_id;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q[owner_q]   <= result_d;
          rsp_ovfl_q[owner_q]  <= ovfl_d;
          rsp_valid_q[owner_q] <= 1'b1;
          state_q              <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_sum   = rsp_sum_q[0];
  assign rsp0_ovfl  = rsp_ovfl_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_sum   = rsp_sum_q[1];
  assign rsp1_ovfl  = rsp_ovfl_q[1];
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sat_adder_arbiter.sv
// Drives a saturating and a wrapping instance with identical traffic; a scoreboard
// checks every response against an integer-arithmetic reference.
module tb_sat_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic        rdy_s0, rdy_s1, rdy_w0, rdy_w1;
  logic        rv_s0, rv_s1, rv_w0, rv_w1;
  logic [15:0] rs_s0, rs_s1, rs_w0, rs_w1;
  logic        ro_s0, ro_s1, ro_w0, ro_w1;
  logic        busy_s, busy_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] sum;
    logic        ovfl;
    int          cyc;
  } exp_t;

  exp_t q_s0[$], q_s1[$], q_w0[$], q_w1[$];
  bit   last_owner = 1'b1;
  int   last_hs    = -10;

  sat_adder_arbiter #(.WIDTH(16), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_sub(s0), .req0_ready(rdy_s0),
    .rsp0_valid(rv_s0), .rsp0_sum(rs_s0), .rsp0_ovfl(ro_s0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_sub(s1), .req1_ready(rdy_s1),
    .rsp1_valid(rv_s1), .rsp1_sum(rs_s1), .rsp1_ovfl(ro_s1),
    .busy(busy_s)
  );

  sat_adder_arbiter #(.WIDTH(16), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_sub(s0), .req0_ready(rdy_w0),
    .rsp0_valid(rv_w0), .rsp0_sum(rs_w0), .rsp0_ovfl(ro_w0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_sub(s1), .req1_ready(rdy_w1),
    .rsp1_valid(rv_w1), .rsp1_sum(rs_w1), .rsp1_ovfl(ro_w1),
    .busy(busy_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: exact signed integer result, then clamp or wrap to 16 bits.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input bit sat, input int c);
    exp_t e;
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r  = sub ? sa - sb : sa + sb;
    e.ovfl = (r > 32767) || (r < -32768);
    if (sat && e.ovfl) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
    else               e.sum = r[15:0];
    e.cyc = c;
    return e;
  endfunction

  task automatic rsp_check(input string name, input logic [15:0] sum, input logic ovfl, input exp_t e);
    check({name, "_sum"}, int'(sum), int'(e.sum));
    check({name, "_ovfl"}, int'(ovfl), int'(e.ovfl));
    check({name, "_latency"}, cyc, e.cyc);
    $display("rsp %s sum=%04h ovfl=%0d cycle=%0d", name, sum, ovfl, cyc);
  endtask

  // Monitor: pops an expectation whenever a response pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rdy_s0 && rdy_s1) check("ready_exclusive", 1, 0);
        if (rv_s0) begin
          if (q_s0.size() == 0) check("rsp_s0_unexpected", 1, 0);
          else begin e = q_s0.pop_front(); rsp_check("s0", rs_s0, ro_s0, e); end
        end
        if (rv_s1) begin
          if (q_s1.size() == 0) check("rsp_s1_unexpected", 1, 0);
          else begin e = q_s1.pop_front(); rsp_check("s1", rs_s1, ro_s1, e); end
        end
        if (rv_w0) begin
          if (q_w0.size() == 0) check("rsp_w0_unexpected", 1, 0);
          else begin e = q_w0.pop_front(); rsp_check("w0", rs_w0, ro_w0, e); end
        end
        if (rv_w1) begin
          if (q_w1.size() == 0) check("rsp_w1_unexpected", 1, 0);
          else begin e = q_w1.pop_front(); rsp_check("w1", rs_w1, ro_w1, e); end
        end
      end
    end
  end

  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic sub);
    int waited = 0;
    bit got = 1'b0;
    if (id == 1'b0) begin v0 = 1'b1; a0 = a; b0 = b; s0 = sub; end
    else            begin v1 = 1'b1; a1 = a; b1 = b; s1 = sub; end
    while (!got && waited < 40) begin
      @(negedge clk);
      if (id == 1'b0 ? rdy_s0 : rdy_s1) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
    end else begin
      if (v0 && v1) check("rr_owner", int'(id), int'(!last_owner));
      check("hs_gap_ge3", int'(cyc - last_hs >= 3), 1);
      $display("req%0d a=%04h b=%04h sub=%0d handshake cycle=%0d", id, a, b, sub, cyc);
      last_owner = id;
      last_hs    = cyc;
      if (id == 1'b0) begin
        q_s0.push_back(model(a, b, sub, 1'b1, cyc + 2));
        q_w0.push_back(model(a, b, sub, 1'b0, cyc + 2));
      end else begin
        q_s1.push_back(model(a, b, sub, 1'b1, cyc + 2));
        q_w1.push_back(model(a, b, sub, 1'b0, cyc + 2));
      end
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy_s), 0);
    check("reset_rsp_valid", int'({rv_s0, rv_s1, rv_w0, rv_w1}), 0);
    check("reset_rsp_sum", int'(rs_s0 | rs_s1), 0);
    check("reset_rsp_ovfl", int'({ro_s0, ro_s1}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 16'h0012, 16'h0034, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_op(1'b1, 16'h7000, 16'h2000, 1'b0);
    do_op(1'b0, 16'h8000, 16'h0001, 1'b1);
    do_op(1'b1, 16'h0005, 16'h0009, 1'b1);
    do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    fork
      begin repeat (4) do_op(1'b0, 16'h0001, 16'h0001, 1'b0); end
      begin repeat (4) do_op(1'b1, 16'h0002, 16'h0002, 1'b0); end
    join
    repeat (3) @(posedge clk);
    #1;

    // Abandon an operation one cycle after its handshake.
    v1 = 1'b1; a1 = 16'h0100; b1 = 16'h0200; s1 = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!rdy_s1 && waited < 40);
    if (!rdy_s1) check("reset_test_grant_timeout", 0, 1);
    @(posedge clk); #1;
    v1 = 1'b0;
    check("exec_busy", int'(busy_s), 1);
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", int'({busy_s, busy_w}), 0);
    check("midop_reset_rsp", int'({rv_s0, rv_s1, rv_w0, rv_w1}), 0);
    last_owner = 1'b1;
    last_hs    = -10;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fork
      begin repeat (2) do_op(1'b0, 16'h0003, 16'h0004, 1'b1); end
      begin repeat (2) do_op(1'b1, 16'h7FF0, 16'h0100, 1'b0); end
    join

    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          do_op(1'b0, pick(), pick(), 1'($urandom));
        end
      end
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          do_op(1'b1, pick(), pick(), 1'($urandom));
        end
      end
    join

    repeat (5) @(negedge clk);
    check("drain_queues", q_s0.size() + q_s1.size() + q_w0.size() + q_w1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sat_adder_arbiter.md
Name: sat_adder_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 16-bit saturating add/sub datapath between two requesters.
Typical requesters are the execute-stage ALU and the address/branch-target unit.
Each requester uses a valid/ready request channel and receives a one-cycle response pulse carrying the saturated result and an overflow flag.
Operands are registered on grant and the result is registered after compute, so the adder sits between two flop stages.

Parameters:
WIDTH, 16, operand/result width; saturation bounds are derived from it (max = 0x7FFF, min = 0x8000 at default).
SAT, 1, 1 = clamp on signed overflow; 0 = two's-complement wrap, ovfl flag still reported.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_sub  input  1  1 = A-B, 0 = A+B
req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid
rsp0_valid  output  1  one-cycle pulse, result for requester 0 valid
rsp0_sum  output  WIDTH  result for requester 0
rsp0_ovfl  output  1  signed overflow occurred on requester 0's op
req1_valid, req1_a, req1_b, req1_sub, req1_ready  same as requester 0, for requester 1
rsp1_valid, rsp1_sum, rsp1_ovfl  same as requester 0, for requester 1
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Async on rst_n low: state=IDLE, all rsp*_valid=0, rsp*_sum=0, rsp*_ovfl=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Operand registers cleared.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready = state==IDLE && grant==X, where grant is decided combinationally from the current valids.
  - Grant rule: only one valid -> that requester. Both valid -> the requester != last_grant.
  - On handshake (valid&ready): latch a, b, sub and owner id; last_grant<=owner; go to EXEC.
  - No valid: stay in IDLE.
- EXEC (one cycle):
  - Adder computes on the latched operands; sub is implemented as A + ~B + 1.
  - Signed overflow:
    - add: a[MSB]==b[MSB] && r[MSB]!=a[MSB]
    - sub: a[MSB]!=b[MSB] && r[MSB]!=a[MSB]
  - SAT=1 and overflow: result = 0x7FFF if a[MSB]==0, else 0x8000. Otherwise the raw result.
  - Result and ovfl are registered into the owner's rsp regs; go to RESP.
- RESP (one cycle):
  - rsp<owner>_valid=1 and the other rsp_valid=0; next state IDLE.
  - rsp_sum/rsp_ovfl hold their value until that requester's next response; they are only meaningful while valid is high.
- Latency: handshake in cycle N -> rsp valid in cycle N+2.
  - The next handshake can occur at the earliest in cycle N+3.
  - Throughput: one op per 3 cycles.
- Requesters must hold valid and operands stable until ready. Requests are not dropped or reordered.
- A requester dropping valid before ready is legal; no grant is issued and last_grant is unchanged.
- No response backpressure: the requester must sample the result during the rsp_valid cycle.
- Reset mid-op (EXEC or RESP): the operation is abandoned and no rsp_valid pulse follows.
- Fairness: under continuous contention the grants alternate 0,1,0,1. Neither requester waits more than one operation.

Test Plan:
- Single add: req0 a=0x0012, b=0x0034, sub=0 -> rsp0_valid exactly 2 cycles after handshake, sum=0x0046, ovfl=0, rsp1_valid stays 0.
- Positive saturation, SAT=1: req1 a=0x7000, b=0x2000 add -> sum=0x7FFF, ovfl=1.
- Negative saturation: a=0x8000, b=0x0001 sub -> 0x8000, ovfl=1.
- Mixed-sign subtract, no overflow: a=0x0005, b=0x0009 sub -> sum=0xFFFC, ovfl=0.
- Contention:
  - Both valid from reset for 4 ops each (req0 adds 1+1, req1 adds 2+2) -> grants 0,1,0,1,...; rsp0 sum=0x0002, rsp1 sum=0x0004.
  - Each handshake is 3 cycles apart; req*_ready is never high simultaneously.
- Reset mid-EXEC:
  - Assert rst_n=0 one cycle after handshake -> busy=0 immediately and no rsp pulse.
  - After release with both valid, requester 0 is granted first.
- Wrap mode, SAT=0: a=0x7FFF, b=0x0001 add -> sum=0x8000, ovfl=1.
